apa_spi_tx: RTL and testbench
=============================

Name: apa_spi_tx

Overview:
- Downstream SPI serializer for the LED wand string.
- Accepts one 32-bit APA102-style frame per handshake from the string sequencer: start, LED or end frame, selected by a type code plus 8-bit blue/green/red values.
- Shifts the frame MSB-first on mosi/sck with a divided clock.
- Holds busy for the whole transfer so the sequencer does not change its colour/type registers mid-frame.

Parameters:
- CLK_DIV, 4, SCK half-period in clock cycles; legal range 1..255.
- GLOBAL_BRIGHTNESS, 31, 5-bit brightness field for LED frames; legal range 0..31.

Ports:
- apa_spi_tx_clk  input  1  system clock
- apa_spi_tx_reset_n  input  1  asynchronous active-low reset
- blue_input  input  8  blue byte for LED frame
- green_input  input  8  green byte for LED frame
- red_input  input  8  red byte for LED frame
- type_input  input  2  0=start frame, 1=LED frame, 2=end frame, 3=reserved
- apa_spi_tx_start  input  1  level request; accepted only while idle
- apa_spi_tx_busy  output  1  high from acceptance until last bit done
- mosi  output  1  serial data
- sck  output  1  serial clock, idle low

Behaviour:
- Clocking and reset:
  - One clock: apa_spi_tx_clk.
  - Reset is asynchronous and active-low on apa_spi_tx_reset_n.
  - While reset is asserted: busy=0, sck=0, mosi=0, shift register and counters=0, state=IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no partial bits resume after release.
- States: IDLE, SHIFT_LOW, SHIFT_HIGH.
- Acceptance (IDLE):
  - If start=1 on a clock edge, latch the 32-bit frame on that edge.
  - On the same edge: busy<=1, mosi<=frame[31], sck<=0, bit index<=31, divider<=0, go to SHIFT_LOW.
  - busy is therefore visible the cycle after start is first sampled high.
  - Start remaining high while busy is ignored.
- Frame composition, latched at acceptance:
  - type 0: 32'h00000000.
  - type 1: {3'b111, brightness[4:0], blue[7:0], green[7:0], red[7:0]}.
  - type 2: 32'hFFFFFFFF.
  - type 3: no transfer. busy=1 for exactly one cycle, sck/mosi stay 0, return to IDLE.
- Inputs may change any time after the acceptance edge without affecting the frame in flight.
- SHIFT_LOW: sck=0 for CLK_DIV cycles, mosi stable; then sck<=1 and go to SHIFT_HIGH.
- SHIFT_HIGH: sck=1 for CLK_DIV cycles, so the receiver samples on the rising edge. Then sck<=0 and:
  - if bit index>0: decrement it, mosi<=next bit, go to SHIFT_LOW;
  - if bit index=0: mosi<=0, busy<=0, go to IDLE.
- Timing:
  - busy high for exactly 64*CLK_DIV cycles per transfer.
  - Exactly 32 sck rising edges per frame.
  - mosi changes only on the edges where sck goes low, or at acceptance.
- Back-to-back: if start is still or again high, there is at least one idle cycle with busy=0 between frames; the next frame is accepted on that idle edge.
- Divider counter is 8 bits and wraps only via explicit reload, never by overflow.

Optional Feature:
- Macro: APA_SPI_TX_BRIGHTNESS_PORT_EN.
- Defined: adds input port brightness_input [4:0], latched at acceptance and used in LED frames; GLOBAL_BRIGHTNESS is ignored.
- Undefined: no such port; LED frames use the GLOBAL_BRIGHTNESS parameter.

Test Plan:
- CLK_DIV=2, type=1, blue=8'h10, green=8'h20, red=8'h30, start pulsed 2 cycles -> mosi sampled on 32 sck rising edges = 32'hFF102030; busy high for 128 cycles, asserted the cycle after start is sampled.
- type=0 then type=2, each started after busy falls -> first frame 32 zero bits, second 32 one bits; mosi=0 and sck=0 afterwards.
- type=3, start pulse -> busy high exactly 1 cycle; zero sck edges; mosi stays 0.
- Start held high continuously, type=1, inputs changed mid-frame -> frames repeat with exactly one busy-low cycle between them; each frame carries the values present at its own acceptance edge.
- Reset_n driven low at sck edge 10 of an LED frame -> busy, sck and mosi go 0 asynchronously; after release with start low, outputs stay idle; a new start gives a complete correct 32-bit frame.
- With APA_SPI_TX_BRIGHTNESS_PORT_EN defined, brightness_input=5'd7, RGB=0 -> frame 32'hE7000000.

Source files
------------

// File: rtl/apa_spi_tx.sv
// apa_spi_tx: APA102-style 32-bit frame serializer, MSB-first on mosi/sck.
// Optional macro APA_SPI_TX_BRIGHTNESS_PORT_EN adds a brightness_input port.
module apa_spi_tx #(
  parameter int CLK_DIV           = 4,
  parameter int GLOBAL_BRIGHTNESS = 31
) (
  input  logic       apa_spi_tx_clk,
  input  logic       apa_spi_tx_reset_n,
  input  logic [7:0] blue_input,
  input  logic [7:0] green_input,
  input  logic [7:0] red_input,
  input  logic [1:0] type_input,
  input  logic       apa_spi_tx_start,
`ifdef APA_SPI_TX_BRIGHTNESS_PORT_EN
  input  logic [4:0] brightness_input,
`endif
  output logic       apa_spi_tx_busy,
  output logic       mosi,
  output logic       sck
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LOW,
    SHIFT_HIGH
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bright;
  logic [31:0] frame;

`ifdef APA_SPI_TX_BRIGHTNESS_PORT_EN
  assign bright = brightness_input;
`else
  assign bright = 5'(GLOBAL_BRIGHTNESS);
`endif

  // Frame image built from the current inputs; only latched on acceptance.
  always_comb begin
    frame = '0;
    unique case (type_input)
      2'd1:    frame = {3'b111, bright, blue_input, green_input, red_input};
      2'd2:    frame = '1;
      default: frame = '0;
    endcase
  end

  // Next-state and output logic for the serializer.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (apa_spi_tx_start) begin
          busy_d = 1'b1;
          if (type_input != 2'd3) begin
            shreg_d = frame;
            mosi_d  = frame[31];
            sck_d   = 1'b0;
            idx_d   = 5'd31;
            div_d   = 8'd0;
            state_d = SHIFT_LOW;
          end
        end
      end
      SHIFT_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          sck_d   = 1'b1;
          state_d = SHIFT_HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          sck_d = 1'b0;
          if (idx_q != 5'd0) begin
            idx_d   = idx_q - 5'd1;
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_q[30];
            state_d = SHIFT_LOW;
          end else begin
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge apa_spi_tx_clk or negedge apa_spi_tx_reset_n) begin
    if (!apa_spi_tx_reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      shreg_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
    end
  end

  assign apa_spi_tx_busy = busy_q;
  assign sck             = sck_q;
  assign mosi            = mosi_q;

endmodule

// File: tb/tb_apa_spi_tx.sv
// tb_apa_spi_tx: table, hand-written and random frames vs. a frame model.
// Also builds with APA_SPI_TX_BRIGHTNESS_PORT_EN defined.
module tb_apa_spi_tx;

  localparam int DIV = 2;
  localparam int GB  = 31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] b_in = '0, g_in = '0, r_in = '0;
  logic [1:0] t_in = '0;
  logic       start = 1'b0;
  logic       busy, mosi, sck;
  logic [4:0] br_in = 5'd31;

  int checks = 0;
  int errors = 0;

  apa_spi_tx #(.CLK_DIV(DIV), .GLOBAL_BRIGHTNESS(GB)) dut (
    .apa_spi_tx_clk     (clk),
    .apa_spi_tx_reset_n (rst_n),
    .blue_input         (b_in),
    .green_input        (g_in),
    .red_input          (r_in),
    .type_input         (t_in),
    .apa_spi_tx_start   (start),
`ifdef APA_SPI_TX_BRIGHTNESS_PORT_EN
    .brightness_input   (br_in),
`endif
    .apa_spi_tx_busy    (busy),
    .mosi               (mosi),
    .sck                (sck)
  );

  always #5 clk = ~clk;

  // Receiver: sample mosi on every sck rising edge.
  logic [31:0] rx = '0;
  int          rises = 0;
  always @(posedge sck) begin
    rx    = {rx[30:0], mosi};
    rises = rises + 1;
  end

  // mosi may only move when sck falls or when a frame is accepted.
  logic mosi_p = 0, sck_p = 0, busy_p = 0, mosi_hi = 0;
  always @(negedge clk) begin
    if (rst_n && mosi !== mosi_p && !(sck_p && !sck) && !(busy && !busy_p)) begin
      errors = errors + 1;
      $display("FAIL mosi_edge: mosi moved to %b without sck fall", mosi);
    end
    if (mosi) mosi_hi = 1'b1;
    mosi_p = mosi;
    sck_p  = sck;
    busy_p = busy;
  end

  function automatic cur_br();
    return 1'b0;
  endfunction

  function automatic logic [31:0] model(logic [1:0] t, logic [7:0] b,
                                        logic [7:0] g, logic [7:0] r,
                                        logic [4:0] br);
    logic [31:0] f;
    case (t)
      2'd1: f = 32'd7 * (1 << 29) + br * (1 << 24) + b * (1 << 16)
                + g * (1 << 8) + r;
      2'd2: f = 32'hFFFF_FFFF;
      default: f = 32'd0;
    endcase
    return f;
  endfunction

  function automatic logic [4:0] eff_br();
`ifdef APA_SPI_TX_BRIGHTNESS_PORT_EN
    return br_in;
`else
    return 5'(GB);
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One frame with start high for two cycles; inputs scrambled after accept.
  task automatic run(logic [1:0] t, logic [7:0] b, logic [7:0] g,
                     logic [7:0] r, logic [31:0] exp);
    int cyc;
    @(negedge clk);
    rx = '0; rises = 0; mosi_hi = 0;
    t_in = t; b_in = b; g_in = g; r_in = r; start = 1'b1;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 1;
    b_in = 8'($urandom); g_in = 8'($urandom); r_in = 8'($urandom);
    t_in = 2'($urandom);
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 4000) begin
      cyc = cyc + 1;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(cyc), (t == 2'd3) ? 32'd1 : 32'(64 * DIV));
    chk("sck_rises", 32'(rises), (t == 2'd3) ? 32'd0 : 32'd32);
    chk("frame", rx, exp);
    chk("idle_out", {30'd0, sck, mosi}, 32'd0);
    if (t == 2'd3) chk("mosi_quiet", 32'(mosi_hi), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  b, g, r;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];
  vec_t bb[4];

  initial begin
    int n;
    logic [31:0] e;
    tbl[0] = '{2'd1, 8'h10, 8'h20, 8'h30, 32'hFF10_2030};
    tbl[1] = '{2'd0, 8'hAA, 8'hBB, 8'hCC, 32'h0000_0000};
    tbl[2] = '{2'd2, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFF};
    tbl[3] = '{2'd3, 8'h55, 8'h66, 8'h77, 32'h0000_0000};
    tbl[4] = '{2'd1, 8'h01, 8'h80, 8'hFE, 32'hFF01_80FE};

    #1;
    chk("reset_out", {29'd0, busy, sck, mosi}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run(tbl[i].t, tbl[i].b, tbl[i].g, tbl[i].r, tbl[i].exp);

    // Start held high: frames repeat with a single idle cycle between.
    for (int i = 0; i < 4; i++)
      bb[i] = '{2'd1, 8'($urandom), 8'($urandom), 8'($urandom), 32'd0};
    @(negedge clk);
    t_in = 2'd1; b_in = bb[0].b; g_in = bb[0].g; r_in = bb[0].r;
    start = 1'b1;
    rx = '0; rises = 0;
    @(negedge clk);
    chk("b2b_busy0", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      e = model(2'd1, bb[k].b, bb[k].g, bb[k].r, eff_br());
      b_in = bb[k+1].b; g_in = bb[k+1].g; r_in = bb[k+1].r;
      n = 0;
      while (busy && n < 4000) begin
        n = n + 1;
        @(negedge clk);
      end
      chk("b2b_frame", rx, e);
      chk("b2b_rises", 32'(rises), 32'd32);
      chk("b2b_gap_low", 32'(busy), 32'd0);
      @(negedge clk);
      chk("b2b_gap_one", 32'(busy), 32'd1);
      rx = '0; rises = 0;
    end
    start = 1'b0;
    n = 0;
    while (busy && n < 4000) begin
      n = n + 1;
      @(negedge clk);
    end
    chk("b2b_last", rx, model(2'd1, bb[3].b, bb[3].g, bb[3].r, eff_br()));

    // Reset at the tenth sck rising edge aborts the frame.
    @(negedge clk);
    t_in = 2'd1; b_in = 8'h12; g_in = 8'h34; r_in = 8'h56; start = 1'b1;
    rises = 0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rises < 10 && n < 1000) begin
      n = n + 1;
      @(negedge clk);
    end
    chk("rst_reach10", 32'(rises), 32'd10);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", {29'd0, busy, sck, mosi}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rises = 0; n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || sck || mosi) n = n + 1;
    end
    chk("rst_stays_idle", 32'(n), 32'd0);
    chk("rst_no_edges", 32'(rises), 32'd0);
    run(2'd1, 8'h12, 8'h34, 8'h56, model(2'd1, 8'h12, 8'h34, 8'h56, eff_br()));

`ifdef APA_SPI_TX_BRIGHTNESS_PORT_EN
    br_in = 5'd7;
    run(2'd1, 8'h00, 8'h00, 8'h00, 32'hE700_0000);
`endif

    // Random frames against the model.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] t;
      logic [7:0] b, g, r;
      t = 2'($urandom_range(0, 3));
      b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
`ifdef APA_SPI_TX_BRIGHTNESS_PORT_EN
      br_in = 5'($urandom);
`endif
      run(t, b, g, r, model(t, b, g, r, eff_br()));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
